// File: rtl/fixed_point_pkg.sv
// Shared Q-format helpers and divider state encoding for the fixed-point
// multiplier/divider pair.
package fixed_point_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        DIVIDE = 3'd2,
        FIX    = 3'd3,
        DONE   = 3'd4
    } div_state_t;

    // Left shift of |A| so the integer quotient carries the wanted fractional bits.
    function automatic int calc_shift(input int q_frac, input int b_frac, input int a_frac);
        return q_frac + b_frac - a_frac;
    endfunction

    function automatic int calc_n_iter(input int a_width, input int shift);
        return a_width + shift;
    endfunction

    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << (width - 32'd1)) - 64'd1;
    endfunction

    // Two's-complement most-negative value, sign-extended to 64 bits.
    function automatic logic [63:0] sat_min(input int unsigned width);
        return ~((64'd1 << (width - 32'd1)) - 64'd1);
    endfunction

endpackage

// File: rtl/fixed_point_div_core.sv
// Unsigned radix-2 restoring division datapath: one quotient bit per step.
module fixed_point_div_core #(
    parameter int unsigned N_ITER  = 30,
    parameter int unsigned D_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [N_ITER-1:0]   dividend,
    input  logic [D_WIDTH-1:0]  divisor,
    output logic [N_ITER-1:0]   quotient,
    output logic                last_c
);

    localparam int unsigned R_WIDTH = D_WIDTH + 1;
    localparam int unsigned CNT_W   = $clog2(N_ITER + 1);

    logic [N_ITER-1:0]  dvd_q;
    logic [D_WIDTH-1:0] dsr_q;
    logic [D_WIDTH-1:0] rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [R_WIDTH-1:0] rem_shift;
    logic [D_WIDTH-1:0] rem_next;
    logic               fits;

    // Remainder stays below the divisor, so D_WIDTH bits hold it between steps.
    always_comb begin
        rem_shift = {rem_q, dvd_q[N_ITER-1]};
        fits      = (rem_shift >= {1'b0, dsr_q});
        rem_next  = fits ? D_WIDTH'(rem_shift - {1'b0, dsr_q})
                         : rem_shift[D_WIDTH-1:0];
    end

    assign last_c = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            quotient <= '0;
        end else if (load) begin
            dvd_q    <= dividend;
            dsr_q    <= divisor;
            rem_q    <= '0;
            cnt_q    <= CNT_W'(N_ITER - 1);
            quotient <= '0;
        end else if (step) begin
            rem_q    <= rem_next;
            dvd_q    <= dvd_q << 1;
            quotient <= {quotient[N_ITER-2:0], fits};
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fixed_point_div.sv
// Iterative signed fixed-point divider Q = A / B with valid/ready on both sides,
// sign restoration, divide-by-zero handling and saturation.
module fixed_point_div
    import fixed_point_pkg::*;
#(
    parameter int unsigned A_WIDTH     = 16,
    parameter int unsigned A_FRAC_BITS = 14,
    parameter int unsigned B_WIDTH     = 16,
    parameter int unsigned B_FRAC_BITS = 14,
    parameter int unsigned Q_FRAC_BITS = 14,
    parameter int unsigned Q_WIDTH     = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic signed [A_WIDTH-1:0]  A,
    input  logic signed [B_WIDTH-1:0]  B,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic signed [Q_WIDTH-1:0]  Q,
    output logic                       div_by_zero_out,
    output logic                       overflow_out
);

    localparam int          SHIFT_S = calc_shift(int'(Q_FRAC_BITS), int'(B_FRAC_BITS),
                                                 int'(A_FRAC_BITS));
    localparam int unsigned SHIFT   = (SHIFT_S < 0) ? 0 : 32'(SHIFT_S);
    localparam int unsigned N_ITER  = 32'(calc_n_iter(int'(A_WIDTH), int'(SHIFT)));
    localparam int unsigned C_WIDTH = ((N_ITER > Q_WIDTH) ? N_ITER : Q_WIDTH) + 1;

    if (SHIFT_S < 0) begin : g_bad_shift
        $error("fixed_point_div: Q_FRAC_BITS + B_FRAC_BITS must be >= A_FRAC_BITS");
    end

    div_state_t          state_q, state_d;
    logic [A_WIDTH-1:0]  a_q;
    logic [B_WIDTH-1:0]  b_q;
    logic                neg_q;
    logic                zero_q;

    logic [A_WIDTH-1:0]  abs_a;
    logic [B_WIDTH-1:0]  abs_b;
    logic [N_ITER-1:0]   dividend;
    logic [N_ITER-1:0]   quotient;
    logic                last_c;
    logic                core_load;
    logic                core_step;

    logic [C_WIDTH-1:0]  mag;
    logic [C_WIDTH-1:0]  pos_lim;
    logic [Q_WIDTH-1:0]  fix_q;
    logic                fix_ovf;

    // W-bit negation of the most-negative value yields 2^(W-1), exact as unsigned.
    always_comb begin
        abs_a     = a_q[A_WIDTH-1] ? (~a_q + A_WIDTH'(1)) : a_q;
        abs_b     = b_q[B_WIDTH-1] ? (~b_q + B_WIDTH'(1)) : b_q;
        dividend  = N_ITER'(abs_a) << SHIFT;
        core_load = (state_q == SETUP);
        core_step = (state_q == DIVIDE);
    end

    fixed_point_div_core #(
        .N_ITER  (N_ITER),
        .D_WIDTH (B_WIDTH)
    ) u_core (
        .clk      (clk_in),
        .rst_n    (rst_n_in),
        .load     (core_load),
        .step     (core_step),
        .dividend (dividend),
        .divisor  (abs_b),
        .quotient (quotient),
        .last_c   (last_c)
    );

    // Sign restoration and clamping of the truncated magnitude.
    always_comb begin
        fix_q   = '0;
        fix_ovf = 1'b0;
        mag     = C_WIDTH'(quotient);
        pos_lim = C_WIDTH'(sat_max(Q_WIDTH));
        if (zero_q) begin
            fix_q = a_q[A_WIDTH-1] ? Q_WIDTH'(sat_min(Q_WIDTH)) : Q_WIDTH'(sat_max(Q_WIDTH));
        end else if (neg_q) begin
            if (mag > pos_lim + C_WIDTH'(1)) begin
                fix_q   = Q_WIDTH'(sat_min(Q_WIDTH));
                fix_ovf = 1'b1;
            end else begin
                fix_q = Q_WIDTH'(~mag + C_WIDTH'(1));
            end
        end else if (mag > pos_lim) begin
            fix_q   = Q_WIDTH'(sat_max(Q_WIDTH));
            fix_ovf = 1'b1;
        end else begin
            fix_q = Q_WIDTH'(mag);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_in && ready_out) state_d = SETUP;
            SETUP:   state_d = DIVIDE;
            DIVIDE:  if (last_c) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ready_out       <= 1'b1;
            valid_out       <= 1'b0;
            Q               <= '0;
            div_by_zero_out <= 1'b0;
            overflow_out    <= 1'b0;
            a_q             <= '0;
            b_q             <= '0;
            neg_q           <= 1'b0;
            zero_q          <= 1'b0;
        end else begin
            ready_out <= (state_d == IDLE);
            valid_out <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (valid_in && ready_out) begin
                        a_q             <= A;
                        b_q             <= B;
                        div_by_zero_out <= 1'b0;
                        overflow_out    <= 1'b0;
                    end
                end
                SETUP: begin
                    neg_q  <= a_q[A_WIDTH-1] ^ b_q[B_WIDTH-1];
                    zero_q <= (b_q == '0);
                end
                FIX: begin
                    Q               <= fix_q;
                    div_by_zero_out <= zero_q;
                    overflow_out    <= fix_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule
